dram_bank_sequencer: RTL and testbench
======================================

DRAM_BANK_SEQUENCER -- requirements
Module: dram_bank_sequencer

Interface
REQ-001 SHALL have parameter IO_WIDTH, default 16, width of the parallel input and output words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, bits per bank address; elaboration SHALL fail unless IO_WIDTH == 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  advance enable; 0 freezes the sequencer.
REQ-006 SHALL have port in  input  IO_WIDTH  parallel word to be written into the write bank.
REQ-007 SHALL have port swap_req  input  1  request to exchange write and read banks.
REQ-008 SHALL have port swap_ack  output  1  one-cycle pulse when a swap has taken effect.
REQ-009 SHALL have port out  output  IO_WIDTH  last complete word read from the read bank.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when out is updated.
REQ-011 SHALL have port wbank  output  1  current write bank; the read bank is ~wbank.
REQ-012 SHALL have ports ram_waddr and ram_raddr  output  ADDR_WIDTH+1  {bank, index} to the write and read address pins of a 2^(ADDR_WIDTH+1) x 1 dual-port distributed RAM.
REQ-013 SHALL have ports ram_we and ram_din  output  1 each  write enable and write data.
REQ-014 SHALL have port ram_dout  input  1  asynchronous read data from the read port.

Function
REQ-015 SHALL keep an index counter idx, 0..IO_WIDTH-1, incremented on each cycle with en=1 and wrapping from IO_WIDTH-1 to 0; a frame is one full pass.
REQ-016 SHALL drive ram_waddr = {wbank, idx} and ram_raddr = {~wbank, idx}, so reads and writes never address the same bank.
REQ-017 SHALL drive ram_we = en, combinationally.
REQ-018 SHALL capture snap <= in on each enabled cycle with idx==0, and drive ram_din = in[0] when idx==0, else snap[idx], so each frame writes one coherent input word.
REQ-019 SHALL sample ram_dout into shadow[idx] on each enabled cycle (zero read latency).
REQ-020 SHALL, on the enabled cycle with idx==IO_WIDTH-1, load out <= shadow with bit IO_WIDTH-1 taken from ram_dout, and assert frame_done for exactly the next cycle.
REQ-021 SHALL set a swap_pending flag on any cycle with swap_req=1; repeated requests within a frame SHALL merge into one swap.
REQ-022 SHALL, on the enabled cycle with idx==IO_WIDTH-1 and (swap_pending or swap_req), toggle wbank, clear swap_pending and pulse swap_ack on the next cycle, coincident with frame_done.
REQ-023 SHALL never change wbank mid-frame.
REQ-024 SHALL, with en=0, hold idx, snap, shadow, out and wbank, keep ram_we=0, and still record swap_req into swap_pending.
REQ-025 SHALL make out change only with frame_done; the first valid out appears IO_WIDTH enabled cycles after reset release.

Reset
REQ-026 SHALL, on clk with rst=1, set idx=0, wbank=0, swap_pending=0, snap=0, shadow=0, out=0, swap_ack=0 and frame_done=0.
REQ-027 SHALL let rst win over en and swap_req; a reset mid-frame abandons that frame, and no partial out or swap_ack is ever produced.
REQ-028 SHALL NOT reset RAM contents; the RAM INIT values remain visible in the first frames after reset.

Structure
REQ-029 SHALL place the IO_WIDTH/ADDR_WIDTH defaults and the {bank, index} address packing helper in the package dram_seq_pkg.
REQ-030 SHALL implement idx as sub-module dram_frame_counter (en, wrap, last-index flag); all other logic SHALL be in dram_bank_sequencer.
REQ-031 SHALL be instantiable against a RAM32X1D at the default parameters: bit 4 of each address to A4/DPRA4, bits 3..0 to A3..A0/DPRA3..DPRA0.

Verification
REQ-032 Reset, en=1, RAM INIT 32'h96A5_96A5 -> after 16 cycles frame_done=1, out=16'h96A5 (bank 1), wbank=0.
REQ-033 in=16'h1234 for frame 1, swap_req pulsed mid-frame 1 -> at end of frame 1 swap_ack=1 and wbank=1; end of frame 2 gives out=16'h1234.
REQ-034 swap_req held high for 40 cycles -> exactly one swap_ack per frame boundary, each coincident with frame_done.
REQ-035 en=0 for 5 cycles at idx=7 -> ram_we=0, idx frozen, frame_done delayed by exactly 5 cycles.
REQ-036 rst at idx=9 with swap_pending=1 -> no swap_ack, out=0, wbank=0; next frame_done 16 enabled cycles later.
REQ-037 in changed from 16'hAAAA to 16'h5555 at idx=8 -> the bank written that frame holds 16'hAAAA.

Source files
------------

// File: rtl/dram_seq_pkg.sv
// Shared defaults and address packing for the
// double-buffered bit-serial DRAM bank sequencer.
package dram_seq_pkg;

  localparam int IO_WIDTH_DEF   = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  // {bank, index} packed into the low aw+1 bits
  function automatic logic [31:0] pack_addr(
    input logic        bank,
    input logic [31:0] idx,
    input int          aw
  );
    return (32'(bank) << aw) | idx;
  endfunction

endpackage

// File: rtl/dram_frame_counter.sv
// Bit index within a frame; wraps after the
// last bit and flags that last position.
module dram_frame_counter
  import dram_seq_pkg::*;
#(
  parameter int IO_WIDTH   = IO_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(IO_WIDTH - 1);

  assign last = (idx == LAST_IDX);

  // advance on enabled cycles, wrap at frame end
  always_ff @(posedge clk) begin
    if (rst)
      idx <= '0;
    else if (en)
      idx <= last ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/dram_bank_sequencer.sv
// Ping-pong sequencer: serialises a word into one
// RAM bank while deserialising the other bank.
module dram_bank_sequencer
  import dram_seq_pkg::*;
#(
  parameter int IO_WIDTH   = IO_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IO_WIDTH-1:0]   in,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic [IO_WIDTH-1:0]   out,
  output logic                  frame_done,
  output logic                  wbank,
  output logic [ADDR_WIDTH:0]   ram_waddr,
  output logic [ADDR_WIDTH:0]   ram_raddr,
  output logic                  ram_we,
  output logic                  ram_din,
  input  logic                  ram_dout
);

  if (IO_WIDTH != 2 ** ADDR_WIDTH) begin : g_bad_width
    $error("IO_WIDTH must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] idx;
  logic                  last;
  logic                  fire;
  logic                  first;
  logic                  swap_pending;
  logic [IO_WIDTH-1:0]   snap;
  logic [IO_WIDTH-1:0]   shadow;
  logic [IO_WIDTH-1:0]   src;
  logic [IO_WIDTH-1:0]   frame;

  dram_frame_counter #(
    .IO_WIDTH  (IO_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .idx (idx),
    .last(last)
  );

  assign fire  = en && last;
  assign first = (idx == '0);

  assign ram_we    = en;
  assign ram_waddr = (ADDR_WIDTH + 1)'(
    pack_addr(wbank, 32'(idx), ADDR_WIDTH));
  assign ram_raddr = (ADDR_WIDTH + 1)'(
    pack_addr(~wbank, 32'(idx), ADDR_WIDTH));

  // bit 0 comes straight from in so the frame
  // serialises the same word that snap captures
  always_comb begin
    src     = first ? in : snap;
    ram_din = src[idx];
    frame   = shadow;
    frame[idx] = ram_dout;
  end

  // latch the word to serialise at frame start
  always_ff @(posedge clk) begin
    if (rst)
      snap <= '0;
    else if (en && first)
      snap <= in;
  end

  // collect read bits; publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      out        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fire;
      if (en)
        shadow <= frame;
      if (fire)
        out <= frame;
    end
  end

  // swap requests merge and apply at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      wbank        <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (fire && (swap_pending || swap_req)) begin
        wbank        <= ~wbank;
        swap_pending <= 1'b0;
        swap_ack     <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_bank_sequencer.sv
// Scoreboard bench for dram_bank_sequencer with
// a behavioural 32x1 dual-port RAM attached.
module tb_dram_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in;
  logic        swap_req;
  logic        swap_ack;
  logic [15:0] out;
  logic        frame_done;
  logic        wbank;
  logic [4:0]  ram_waddr;
  logic [4:0]  ram_raddr;
  logic        ram_we;
  logic        ram_din;
  logic        ram_dout;

  logic [31:0] ram = 32'h96A5_96A5;

  typedef struct {
    logic [15:0] out;
    logic        ack;
    logic        wb;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rel_cyc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we)
      ram[ram_waddr] <= ram_din;
  end

  assign ram_dout = ram[ram_raddr];

  dram_bank_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .out       (out),
    .frame_done(frame_done),
    .wbank     (wbank),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h",
               name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pop one expectation per frame_done
  always @(negedge clk) begin
    if (swap_ack) begin
      checks++;
      if (!frame_done) begin
        failures++;
        $display("FAIL ack_with_done: got frame_done=0, expected 1");
      end
    end
    if (frame_done) begin
      exp_t e;
      done_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame: got out=%h, expected no frame", out);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.out || swap_ack !== e.ack ||
            wbank !== e.wb) begin
          failures++;
          $display("FAIL frame: got out=%h ack=%b wbank=%b, expected out=%h ack=%b wbank=%b",
                   out, swap_ack, wbank, e.out, e.ack, e.wb);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    in = '0;
    swap_req = 1'b0;
    repeat (3) tick();

    chk("rst_out", 32'(out), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_ack", 32'(swap_ack), 32'h0);
    chk("rst_wbank", 32'(wbank), 32'h0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'd16);
    chk("rst_we", 32'(ram_we), 32'h0);

    // frame 1: RAM init read out, swap mid-frame
    rst = 1'b0;
    en = 1'b1;
    in = 16'h1234;
    exp_q.push_back('{16'h96A5, 1'b1, 1'b1});
    repeat (5) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (10) tick();

    // frame 2: input changes at idx 8, swap again
    in = 16'hAAAA;
    exp_q.push_back('{16'h1234, 1'b1, 1'b0});
    repeat (8) tick();
    in = 16'h5555;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (7) tick();
    chk("bank1_coherent", 32'(ram[31:16]), 32'hAAAA);

    // frames 3..5: swap_req held 40 cycles
    in = 16'h0F0F;
    swap_req = 1'b1;
    exp_q.push_back('{16'hAAAA, 1'b1, 1'b1});
    repeat (16) tick();
    in = 16'hC3C3;
    exp_q.push_back('{16'h0F0F, 1'b1, 1'b0});
    repeat (16) tick();
    in = 16'h5A5A;
    exp_q.push_back('{16'hC3C3, 1'b1, 1'b1});
    repeat (7) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1)
        swap_req = 1'b0;
      chk("frz_we", 32'(ram_we), 32'h0);
      chk("frz_idx", 32'(ram_waddr), 32'd7);
      tick();
    end
    en = 1'b1;
    repeat (9) tick();

    // frame 6: pending swap then reset at idx 9
    in = 16'hFFFF;
    repeat (3) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (5) tick();
    chk("pre_rst_idx", 32'(ram_waddr), 32'd25);
    rst = 1'b1;
    en = 1'b0;
    tick();
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_wbank", 32'(wbank), 32'h0);
    chk("mid_rst_ack", 32'(swap_ack), 32'h0);
    chk("mid_rst_idx", 32'(ram_waddr), 32'd0);

    // frame 7: partial bank 1 write is visible
    rst = 1'b0;
    en = 1'b1;
    in = 16'h0000;
    rel_cyc = cyc;
    exp_q.push_back('{16'hC3FF, 1'b0, 1'b0});
    repeat (16) tick();
    en = 1'b0;
    repeat (3) tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_count", 32'(done_q.size()), 32'd6);
    if (done_q.size() >= 6) begin
      chk("freeze_delay", 32'(done_q[4] - done_q[3]), 32'd21);
      chk("post_rst_lat", 32'(done_q[5] - rel_cyc), 32'd16);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
